// File: rtl/icache.sv
`timescale 1ns/1ps
// icache: read-only direct-mapped instruction cache, 8 lines x 4 words, one refill outstanding.
// Latency: hits return the word combinationally in the same cycle. A miss costs (memory latency + 2) cycles.
// Backpressure: proc_stall holds the fetch until the refill ends. Optional counters are enabled by the macro ICACHE_STATS_EN.
module icache (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         proc_read,
  input  logic         proc_write,
  input  logic [29:0]  proc_addr,
  input  logic [31:0]  proc_wdata,
  output logic         proc_stall,
  output logic [31:0]  proc_rdata,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic         mem_ready,
  input  logic [127:0] mem_rdata
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]  hit_cnt,
  output logic [31:0]  miss_cnt
`endif
);

  typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [7:0]    valid;
  logic [24:0]   tag_arr  [8];
  logic [127:0]  data_arr [8];
  logic [27:0]   miss_line;

  logic [1:0]    offset;
  logic [2:0]    index;
  logic [24:0]   tag;
  logic          hit;
  logic          lookup_hit;
  logic          lookup_miss;
  logic          refill;
  logic          unused_ok;

  assign offset = proc_addr[1:0];
  assign index  = proc_addr[4:2];
  assign tag    = proc_addr[29:5];

  // The cache never writes, so the processor write port is deliberately left unconnected.
  assign unused_ok = ^{proc_write, proc_wdata};

  assign hit         = valid[index] && (tag_arr[index] == tag);
  assign lookup_hit  = (state == IDLE) && proc_read && hit;
  assign lookup_miss = (state == IDLE) && proc_read && !hit;
  // A refill is only accepted while FETCH is waiting. A stray mem_ready in IDLE is dropped.
  assign refill      = (state == FETCH) && mem_ready;

  assign mem_write = 1'b0;
  assign mem_wdata = '0;

  // State register. Reset aborts any refill in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (lookup_miss) state_nxt = FETCH;
      FETCH:   if (mem_ready)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic. Reset masks the stall, because a stall is otherwise raised by the invalid lines on any read.
  always_comb begin
    proc_stall = 1'b0;
    mem_read   = 1'b0;
    mem_addr   = '0;
    proc_rdata = data_arr[index][{offset, 5'd0} +: 32];
    case (state)
      IDLE:    proc_stall = rst_n && lookup_miss;
      FETCH: begin
        proc_stall = 1'b1;
        mem_read   = 1'b1;
        mem_addr   = miss_line;
      end
      default: ;
    endcase
  end

  // Capture the missing line address. The refill then ignores later changes to proc_addr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           miss_line <= '0;
    else if (lookup_miss) miss_line <= proc_addr[29:2];
  end

  // Valid bits. This is the only cache state that needs reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      valid <= '0;
    else if (refill) valid[miss_line[2:0]] <= 1'b1;
  end

  // Tag and data arrays. A refill overwrites the victim line without any check.
  always_ff @(posedge clk) begin
    if (refill) begin
      tag_arr[miss_line[2:0]]  <= miss_line[27:3];
      data_arr[miss_line[2:0]] <= mem_rdata;
    end
  end

`ifdef ICACHE_STATS_EN
  // Hit and miss counters. Both wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (lookup_hit)  hit_cnt  <= hit_cnt + 32'd1;
      if (lookup_miss) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`else
  logic unused_hit;
  assign unused_hit = lookup_hit;
`endif

endmodule
